spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of the rate and ISI counters.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: decoder enable.
REQ-005 SHALL have port spike_in, input, 1 bit: spike output of the LIF neuron stage.
REQ-006 SHALL have port win_sel, input, 2 bits: window length select; 0=16, 1=64, 2=256, 3=1024 cycles.
REQ-007 SHALL have port rate_out, output, CNT_W bits: spike count of the last completed window.
REQ-008 SHALL have port rate_valid, output, 1 bit: rate_out holds an unconsumed result.
REQ-009 SHALL have port rate_ready, input, 1 bit: consumer accepts rate_out.
REQ-010 SHALL have port isi_out, output, CNT_W bits: cycles between the last two spike events.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, set when a result was overwritten before it was consumed.

Function
REQ-012 SHALL define a spike event as spike_in=1 in a cycle where the registered previous spike_in=0 (rising edge).
REQ-013 SHALL implement the FSM states IDLE and COUNT: IDLE->COUNT when en=1; COUNT->IDLE when en=0.
REQ-014 SHALL, on entering COUNT, latch win_sel into win_len and clear the window and spike counters; a win_sel change mid-window takes effect only at the next window start.
REQ-015 SHALL, in COUNT, increment the window counter every cycle and the spike counter on each spike event, saturating at 2^CNT_W-1.
REQ-016 SHALL treat the cycle where the window counter equals win_len-1 as window end: it latches the spike count, including any spike event in that same cycle, into rate_out, sets rate_valid, restarts both counters at 0, and relatches win_sel.
REQ-017 SHALL keep rate_out and rate_valid stable while rate_valid=1 and rate_ready=0.
REQ-018 SHALL clear rate_valid on the cycle after rate_valid=1 and rate_ready=1.
REQ-019 SHALL, when a window end coincides with a transfer (rate_valid=1 and rate_ready=1), load the new result and keep rate_valid=1, without setting overrun.
REQ-020 SHALL, when a window end occurs with rate_valid=1 and rate_ready=0, overwrite rate_out with the new result and set overrun; overrun clears only on rst.
REQ-021 SHALL count cycles since the previous spike event with a saturating ISI counter; on each spike event after the first event since reset or IDLE, it latches the counter plus 1 (saturating) into isi_out and restarts the counter.
REQ-022 SHALL hold isi_out at its last value when en is deasserted.
REQ-023 SHALL, on en falling, discard the partial window without producing a result, while keeping rate_out, rate_valid and the handshake alive.
REQ-024 SHALL make all outputs registered, with zero combinational paths from input to output.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set the state to IDLE and clear rate_out, rate_valid, isi_out, overrun, all counters, the previous-spike register and the first-event flag to 0.
REQ-026 SHALL give rst priority over en, rate_ready and spike_in in the same cycle, including mid-window and mid-handshake.

Structure
REQ-027 SHALL place the window length constants (16/64/256/1024), the win_sel encoding and the FSM state enum in the shared package snn_pkg.
REQ-028 SHALL use one sub-module, sat_counter (parameterised width, with inc, clr and saturating output), instanced for the spike and ISI counters; the window counter is a plain 10-bit counter.
REQ-029 SHALL target 120-400 lines of RTL.

Verification
REQ-030 SHALL cover: en=1, win_sel=0, one single-cycle spike every 4 cycles -> rate_out=4, rate_valid rising at cycle 16 after entering COUNT; isi_out=4.
REQ-031 SHALL cover: spike_in held high for 100 cycles, win_sel=1 -> rate_out=1 (edges only), with no further rise in rate_out in the following windows.
REQ-032 SHALL cover: win_sel=2, a spike every 2 cycles with CNT_W=8 -> rate_out=128; with a spike every cycle (toggle 1/0 impossible) force CNT_W=6 -> rate_out saturates at 63.
REQ-033 SHALL cover: rate_ready=0 across two window ends -> rate_out shows the second count and overrun=1; then rate_ready=1 -> rate_valid=0 on the next cycle and overrun stays 1.
REQ-034 SHALL cover: a spike event on the window-end cycle combined with rate_ready=1 -> that spike is counted in the closing window and rate_valid stays 1 continuously.
REQ-035 SHALL cover: rst=1 asserted mid-window with rate_valid=1 -> every output is 0 on the next cycle; after en=1 the first spike produces no isi_out update.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike-rate decoder: window-select
// encoding, window lengths and the decoder FSM states.
package snn_pkg;

  localparam int unsigned WIN_CNT_W    = 10;
  localparam int unsigned WIN_LEN_16   = 16;
  localparam int unsigned WIN_LEN_64   = 64;
  localparam int unsigned WIN_LEN_256  = 256;
  localparam int unsigned WIN_LEN_1024 = 1024;

  typedef enum logic [1:0] {
    WIN_SEL_16   = 2'd0,
    WIN_SEL_64   = 2'd1,
    WIN_SEL_256  = 2'd2,
    WIN_SEL_1024 = 2'd3
  } win_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Window-counter value of the last cycle in a window.
  function automatic logic [WIN_CNT_W-1:0] win_last(input win_sel_e sel);
    case (sel)
      WIN_SEL_16:  win_last = WIN_CNT_W'(WIN_LEN_16 - 1);
      WIN_SEL_64:  win_last = WIN_CNT_W'(WIN_LEN_64 - 1);
      WIN_SEL_256: win_last = WIN_CNT_W'(WIN_LEN_256 - 1);
      default:     win_last = WIN_CNT_W'(WIN_LEN_1024 - 1);
    endcase
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result bundle of the spike-rate decoder: rate valid/ready handshake plus
// the ISI and overrun status that travel with it.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic             rate_ready;
  logic [CNT_W-1:0] isi_out;
  logic             overrun;

  modport master (
    output rate_out, rate_valid, isi_out, overrun,
    input  rate_ready
  );

  modport slave (
    input  rate_out, rate_valid, isi_out, overrun,
    output rate_ready
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full_o = &cnt_q;
  assign cnt_o  = cnt_q;

  // NOTE: every variable driven in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (inc_i && !full_o) cnt_d = cnt_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts rising-edge spike events over a selectable window, publishes the
// count through a valid/ready handshake and tracks the inter-spike interval.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [1:0]       win_sel,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] isi_out,
  output logic             overrun
);

  state_e                 state_q, state_d;
  win_sel_e               win_len_q, win_len_d;
  logic [WIN_CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic                   spike_prev_q;
  logic                   first_seen_q, first_seen_d;
  logic [CNT_W-1:0]       rate_q, rate_d;
  logic                   rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0]       isi_q, isi_d;
  logic                   overrun_q, overrun_d;

  logic                   active, spike_evt, win_end;
  logic [CNT_W-1:0]       spk_cnt, isi_cnt, spk_next, isi_next;
  logic                   spk_full, isi_full;

  // A cycle with en low is never counted, so a falling en discards the window.
  assign active    = (state_q == ST_COUNT) && en;
  assign spike_evt = spike_in && !spike_prev_q;
  assign win_end   = active && (win_cnt_q == win_last(win_len_q));
  assign spk_next  = spk_full ? spk_cnt : spk_cnt + CNT_W'(1);
  assign isi_next  = isi_full ? isi_cnt : isi_cnt + CNT_W'(1);

  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!active || win_end),
    .inc_i  (active && spike_evt),
    .cnt_o  (spk_cnt),
    .full_o (spk_full)
  );

  sat_counter #(.W(CNT_W)) u_isi_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!active || spike_evt),
    .inc_i  (active),
    .cnt_o  (isi_cnt),
    .full_o (isi_full)
  );

  always_comb begin
    state_d      = state_q;
    win_len_d    = win_len_q;
    win_cnt_d    = '0;
    first_seen_d = 1'b0;
    rate_d       = rate_q;
    rate_valid_d = rate_valid_q;
    isi_d        = isi_q;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_COUNT;
          win_len_d = win_sel_e'(win_sel);
        end
      end
      ST_COUNT: if (!en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (active) begin
      win_cnt_d    = win_end ? '0 : win_cnt_q + WIN_CNT_W'(1);
      first_seen_d = first_seen_q || spike_evt;
      if (spike_evt && first_seen_q) isi_d = isi_next;
    end

    // A window end that meets a pending, unaccepted result overwrites it.
    if (win_end) begin
      rate_d       = spike_evt ? spk_next : spk_cnt;
      rate_valid_d = 1'b1;
      win_len_d    = win_sel_e'(win_sel);
      if (rate_valid_q && !rate_ready) overrun_d = 1'b1;
    end else if (rate_valid_q && rate_ready) begin
      rate_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      win_len_q    <= WIN_SEL_16;
      win_cnt_q    <= '0;
      spike_prev_q <= 1'b0;
      first_seen_q <= 1'b0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_len_q    <= win_len_d;
      win_cnt_q    <= win_cnt_d;
      spike_prev_q <= spike_in;
      first_seen_q <= first_seen_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      isi_q        <= isi_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: an 8-bit and a 6-bit instance share
// stimulus; expected rates go into queues popped by per-instance monitors.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       spike_in = 1'b0;
  logic       rate_ready = 1'b0;
  logic [1:0] win_sel = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int q8[$];
  int q6[$];

  spike_rate_decoder_if #(.CNT_W(8)) bus8 ();
  spike_rate_decoder_if #(.CNT_W(6)) bus6 ();

  assign bus8.rate_ready = rate_ready;
  assign bus6.rate_ready = rate_ready;

  spike_rate_decoder #(.CNT_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .win_sel    (win_sel),
    .rate_out   (bus8.rate_out),
    .rate_valid (bus8.rate_valid),
    .rate_ready (bus8.rate_ready),
    .isi_out    (bus8.isi_out),
    .overrun    (bus8.overrun)
  );

  spike_rate_decoder #(.CNT_W(6)) dut6 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .win_sel    (win_sel),
    .rate_out   (bus6.rate_out),
    .rate_valid (bus6.rate_valid),
    .rate_ready (bus6.rate_ready),
    .isi_out    (bus6.isi_out),
    .overrun    (bus6.overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected window result for both instances (6-bit one saturates at 63).
  task automatic push(input int v);
    q8.push_back(v);
    q6.push_back(v > 63 ? 63 : v);
  endtask

  always @(negedge clk) begin
    if (!rst && bus8.rate_valid && rate_ready) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rate8_unexpected: got %0d, expected no result", bus8.rate_out);
      end else begin
        check("rate8", int'(bus8.rate_out), q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus6.rate_valid && rate_ready) begin
      if (q6.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rate6_unexpected: got %0d, expected no result", bus6.rate_out);
      end else begin
        check("rate6", int'(bus6.rate_out), q6.pop_front());
      end
    end
  end

  task automatic step(input logic e, input logic s, input logic r);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    en         = e;
    spike_in   = s;
    rate_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    en         = 1'b0;
    spike_in   = 1'b0;
    rate_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    check("rst_rate8", int'(bus8.rate_out), 0);
    check("rst_valid8", int'(bus8.rate_valid), 0);
    check("rst_isi8", int'(bus8.isi_out), 0);
    check("rst_ovr8", int'(bus8.overrun), 0);
    check("rst_valid6", int'(bus6.rate_valid), 0);

    // 16-cycle window, spike every 4 cycles
    win_sel = 2'd0;
    push(4);
    push(4);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 33; k++) begin
      step(1'b1, (k % 4) == 0, 1'b1);
      if (k == 10) check("isi_period4", int'(bus8.isi_out), 4);
      if (k == 15) check("valid_before_end", int'(bus8.rate_valid), 0);
      if (k == 16) check("valid_at_16", int'(bus8.rate_valid), 1);
      if (k == 17) check("valid_cleared", int'(bus8.rate_valid), 0);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("isi_hold_idle", int'(bus8.isi_out), 4);

    // Spike held high: only the rising edge counts
    do_reset();
    win_sel = 2'd1;
    push(1);
    push(0);
    push(0);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 193; k++) step(1'b1, k < 100, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // 256-cycle window, spike every 2 cycles: 128, saturating at 63 in 6 bits
    do_reset();
    win_sel = 2'd2;
    push(128);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k <= 257; k++) begin
      step(1'b1, (k % 2) == 0, 1'b1);
      if (k == 100) check("isi_period2", int'(bus8.isi_out), 2);
    end
    step(1'b0, 1'b0, 1'b1);

    // Two window ends without acceptance: overwrite and sticky overrun
    do_reset();
    win_sel = 2'd0;
    push(8);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      step(1'b1, (k < 16) ? ((k % 4) == 0) : ((k < 32) && ((k % 2) == 0)), 1'b0);
      if (k == 20) begin
        check("held_rate", int'(bus8.rate_out), 4);
        check("held_valid", int'(bus8.rate_valid), 1);
        check("no_ovr_yet", int'(bus8.overrun), 0);
      end
      if (k == 32) begin
        check("ovr_rate", int'(bus8.rate_out), 8);
        check("ovr_set8", int'(bus8.overrun), 1);
        check("ovr_set6", int'(bus6.overrun), 1);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("ovr_drain_valid", int'(bus8.rate_valid), 0);
    check("ovr_sticky", int'(bus8.overrun), 1);

    // Window end coinciding with a transfer, spike on the end cycle
    do_reset();
    win_sel = 2'd0;
    push(4);
    push(3);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      step(1'b1, ((k % 4) == 3) && (k != 19), k >= 31);
      if (k == 31) check("cont_valid_31", int'(bus8.rate_valid), 1);
      if (k == 32) begin
        check("cont_valid_32", int'(bus8.rate_valid), 1);
        check("end_spike_rate", int'(bus8.rate_out), 3);
        check("cont_no_ovr", int'(bus8.overrun), 0);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    check("cont_valid_done", int'(bus8.rate_valid), 0);

    // Reset mid-window and mid-handshake
    do_reset();
    win_sel = 2'd0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 35; k++) step(1'b1, (k % 4) == 0, 1'b0);
    check("pre_rst_ovr", int'(bus8.overrun), 1);
    check("pre_rst_isi", int'(bus8.isi_out), 4);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    en         = 1'b1;
    spike_in   = 1'b1;
    rate_ready = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0);
    check("mid_rst_rate8", int'(bus8.rate_out), 0);
    check("mid_rst_valid8", int'(bus8.rate_valid), 0);
    check("mid_rst_isi8", int'(bus8.isi_out), 0);
    check("mid_rst_ovr8", int'(bus8.overrun), 0);
    check("mid_rst_rate6", int'(bus6.rate_out), 0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, (k == 2) || (k == 5), 1'b0);
      if (k == 4) check("first_spike_no_isi", int'(bus8.isi_out), 0);
      if (k == 7) check("second_spike_isi", int'(bus8.isi_out), 3);
    end
    step(1'b0, 1'b0, 1'b0);

    check("q8_drained", q8.size(), 0);
    check("q6_drained", q6.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
